// File: rtl/host_cmd_parser_if.sv
// Register-bus and UART handshake bundle for host_cmd_parser.
// master = parser side, slave = UART/bus environment side.
interface host_cmd_parser_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [7:0]            iRX_DATA;
    logic                  iRX_VALID;
    logic [7:0]            oTX_DATA;
    logic                  oTX_VALID;
    logic                  iTX_READY;
    logic [ADDR_WIDTH-1:0] oADDR;
    logic                  oWE;
    logic                  oRE;
    logic [7:0]            oDATA;
    logic                  iRD_EN;
    logic [7:0]            iRD;
    logic                  oERR;

    modport master (
        input  iRX_DATA, iRX_VALID, iTX_READY, iRD_EN, iRD,
        output oTX_DATA, oTX_VALID, oADDR, oWE, oRE, oDATA, oERR
    );

    modport slave (
        output iRX_DATA, iRX_VALID, iTX_READY, iRD_EN, iRD,
        input  oTX_DATA, oTX_VALID, oADDR, oWE, oRE, oDATA, oERR
    );
endinterface

// File: rtl/host_cmd_parser.sv
// Decodes 'W' hi lo data / 'R' hi lo byte frames into register bus strobes.
// Define HOST_CMD_WR_ACK_EN to transmit 'K' (0x4B) after every completed write.
module host_cmd_parser #(
    parameter int ADDR_WIDTH = 16,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    host_cmd_parser_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR_H, ADDR_L, DATA, WR_STB, RD_STB, RD_WAIT, TX
    } state_t;

    localparam logic [7:0]  CMD_WR       = 8'h57;
    localparam logic [7:0]  CMD_RD       = 8'h52;
    localparam logic [7:0]  TIMEOUT_BYTE = 8'hFF;
    localparam logic [15:0] CNT_LAST     = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;
`ifdef HOST_CMD_WR_ACK_EN
    localparam logic [7:0]  ACK_BYTE     = 8'h4B;
`endif

    state_t                state_r, state_next_s;
    logic                  wr_flag_r, wr_flag_next_s;
    logic [7:0]            addr_hi_r, addr_hi_next_s;
    logic [7:0]            addr_lo_r, addr_lo_next_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
    logic [7:0]            data_r, data_next_s;
    logic                  we_r, we_next_s;
    logic                  re_r, re_next_s;
    logic                  err_r, err_next_s;
    logic                  tx_valid_r, tx_valid_next_s;
    logic [7:0]            tx_data_r, tx_data_next_s;
    logic [15:0]           cnt_r, cnt_next_s;
    logic [15:0]           frame_addr_s;
    logic                  busy_s;
    logic                  drop_s;

    // Any byte arriving while a command is executing is discarded and flagged.
    assign busy_s = (state_r == WR_STB) || (state_r == RD_STB) ||
                    (state_r == RD_WAIT) || (state_r == TX);
    assign drop_s = busy_s && bus.iRX_VALID;

    // Next-state and next-output decode.
    always_comb begin
        state_next_s    = state_r;
        wr_flag_next_s  = wr_flag_r;
        addr_hi_next_s  = addr_hi_r;
        addr_lo_next_s  = addr_lo_r;
        addr_next_s     = addr_r;
        data_next_s     = data_r;
        we_next_s       = 1'b0;
        re_next_s       = 1'b0;
        err_next_s      = drop_s;
        tx_valid_next_s = tx_valid_r;
        tx_data_next_s  = tx_data_r;
        cnt_next_s      = cnt_r;
        frame_addr_s    = {addr_hi_r, addr_lo_r};

        case (state_r)
            IDLE: begin
                if (bus.iRX_VALID && (bus.iRX_DATA == CMD_WR)) begin
                    wr_flag_next_s = 1'b1;
                    state_next_s   = ADDR_H;
                end else if (bus.iRX_VALID && (bus.iRX_DATA == CMD_RD)) begin
                    wr_flag_next_s = 1'b0;
                    state_next_s   = ADDR_H;
                end else if (bus.iRX_VALID) begin
                    err_next_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR_H: begin
                if (bus.iRX_VALID) begin
                    addr_hi_next_s = bus.iRX_DATA;
                    state_next_s   = ADDR_L;
                end else begin
                    state_next_s = ADDR_H;
                end
            end
            ADDR_L: begin
                frame_addr_s = {addr_hi_r, bus.iRX_DATA};
                if (bus.iRX_VALID && wr_flag_r) begin
                    addr_lo_next_s = bus.iRX_DATA;
                    state_next_s   = DATA;
                end else if (bus.iRX_VALID) begin
                    // Read strobe is registered here so oRE lands one cycle after addr_lo.
                    addr_lo_next_s = bus.iRX_DATA;
                    addr_next_s    = frame_addr_s[ADDR_WIDTH-1:0];
                    re_next_s      = 1'b1;
                    state_next_s   = RD_STB;
                end else begin
                    state_next_s = ADDR_L;
                end
            end
            DATA: begin
                if (bus.iRX_VALID) begin
                    addr_next_s  = frame_addr_s[ADDR_WIDTH-1:0];
                    data_next_s  = bus.iRX_DATA;
                    we_next_s    = 1'b1;
                    state_next_s = WR_STB;
                end else begin
                    state_next_s = DATA;
                end
            end
            WR_STB: begin
`ifdef HOST_CMD_WR_ACK_EN
                tx_data_next_s  = ACK_BYTE;
                tx_valid_next_s = 1'b1;
                state_next_s    = TX;
`else
                state_next_s    = IDLE;
`endif
            end
            RD_STB: begin
                cnt_next_s   = 16'h0000;
                state_next_s = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.iRD_EN) begin
                    tx_data_next_s  = bus.iRD;
                    tx_valid_next_s = 1'b1;
                    state_next_s    = TX;
                end else if (cnt_r == CNT_LAST) begin
                    tx_data_next_s  = TIMEOUT_BYTE;
                    tx_valid_next_s = 1'b1;
                    err_next_s      = 1'b1;
                    state_next_s    = TX;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_next_s = cnt_r + 16'h0001;
                end else begin
                    cnt_next_s = CNT_MAX;
                end
            end
            TX: begin
                if (tx_valid_r && bus.iTX_READY) begin
                    tx_valid_next_s = 1'b0;
                    state_next_s    = IDLE;
                end else begin
                    state_next_s = TX;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            wr_flag_r  <= 1'b0;
            addr_hi_r  <= 8'h00;
            addr_lo_r  <= 8'h00;
            addr_r     <= '0;
            data_r     <= 8'h00;
            we_r       <= 1'b0;
            re_r       <= 1'b0;
            err_r      <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            cnt_r      <= 16'h0000;
        end else begin
            state_r    <= state_next_s;
            wr_flag_r  <= wr_flag_next_s;
            addr_hi_r  <= addr_hi_next_s;
            addr_lo_r  <= addr_lo_next_s;
            addr_r     <= addr_next_s;
            data_r     <= data_next_s;
            we_r       <= we_next_s;
            re_r       <= re_next_s;
            err_r      <= err_next_s;
            tx_valid_r <= tx_valid_next_s;
            tx_data_r  <= tx_data_next_s;
            cnt_r      <= cnt_next_s;
        end
    end

    assign bus.oADDR     = addr_r;
    assign bus.oDATA     = data_r;
    assign bus.oWE       = we_r;
    assign bus.oRE       = re_r;
    assign bus.oERR      = err_r;
    assign bus.oTX_VALID = tx_valid_r;
    assign bus.oTX_DATA  = tx_data_r;
endmodule

// File: tb/tb_host_cmd_parser.sv
// Scoreboard bench for host_cmd_parser: frame-level model predicts strobes,
// error pulses and transmitted bytes with their cycle numbers.
module tb_host_cmd_parser;
    localparam int AW = 16;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RST_N;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    host_cmd_parser_if #(.ADDR_WIDTH(AW)) bus ();

    host_cmd_parser #(.ADDR_WIDTH(AW), .RD_TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } ev_t;

    ev_t we_q[$];
    ev_t re_q[$];
    ev_t tx_q[$];
    int  err_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Optional idle gap, then one received byte; returns the cycle it was valid in.
    task automatic send_byte(input logic [7:0] b, input int maxgap, output int sent);
        repeat ($urandom_range(0, maxgap)) step();
        bus.iRX_DATA  = b;
        bus.iRX_VALID = 1'b1;
        sent = cyc;
        step();
        bus.iRX_VALID = 1'b0;
        bus.iRX_DATA  = 8'($urandom);
    endtask

    task automatic tx_handshake(input int rise, input int hold);
        while (cyc < rise + hold) step();
        bus.iTX_READY = 1'b1;
        step();
        bus.iTX_READY = 1'b0;
    endtask

    task automatic do_reset(input int n);
        RST_N          = 1'b0;
        bus.iRX_VALID  = 1'b0;
        bus.iRD_EN     = 1'b0;
        bus.iTX_READY  = 1'b0;
        repeat (n) step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int maxgap, input int hold);
        int n;
        send_byte(8'h57, maxgap, n);
        send_byte(a[15:8], maxgap, n);
        send_byte(a[7:0], maxgap, n);
        send_byte(d, maxgap, n);
        we_q.push_back('{a, d, n + 1});
`ifdef HOST_CMD_WR_ACK_EN
        tx_q.push_back('{16'h0000, 8'h4B, n + 2});
        tx_handshake(n + 2, hold);
`else
        if (hold >= 0) step();
`endif
    endtask

    // d = cycles after oRE at which iRD_EN is driven; 0 means the bus never answers.
    task automatic do_read(input logic [15:0] a, input int d, input logic [7:0] rdv,
                           input int hold, input bit junk, input bit abort);
        int n;
        int re_c;
        int rise;
        logic [7:0] jb;
        bit answered;
        send_byte(8'h52, 2, n);
        send_byte(a[15:8], 2, n);
        send_byte(a[7:0], 2, n);
        re_c = n + 1;
        re_q.push_back('{a, 8'h00, re_c});
        answered = (d >= 1) && (d <= TO);
        rise = answered ? (re_c + d + 1) : (re_c + TO + 1);
        jb = 8'($urandom);
        if (junk) err_q.push_back(re_c + 2);
        if (!answered) err_q.push_back(rise);
        tx_q.push_back('{16'h0000, answered ? rdv : 8'hFF, rise});
        while (cyc < rise) begin
            bus.iRX_VALID = junk && (cyc == re_c + 1);
            bus.iRX_DATA  = jb;
            bus.iRD_EN    = answered && (cyc == re_c + d);
            bus.iRD       = (answered && (cyc == re_c + d)) ? rdv : 8'($urandom);
            step();
        end
        bus.iRX_VALID = 1'b0;
        bus.iRD_EN    = 1'b0;
        if (abort) begin
            repeat (2) step();
            do_reset(3);
        end else begin
            tx_handshake(rise, hold);
        end
    endtask

    task automatic do_junk();
        logic [7:0] b;
        int n;
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        send_byte(b, 2, n);
        err_q.push_back(n + 1);
    endtask

    task automatic stray_rd_en();
        bus.iRD_EN = 1'b1;
        bus.iRD    = 8'($urandom);
        step();
        bus.iRD_EN = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge CLK) begin
        ev_t e;
        int  c;
        if (!RST_N) begin
            chk("reset_addr_data", 32'({bus.oADDR, bus.oDATA}), 32'h0);
            chk("reset_ctrl", 32'({bus.oWE, bus.oRE, bus.oERR, bus.oTX_VALID, bus.oTX_DATA}), 32'h0);
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.oWE) begin
                if (we_q.size() == 0) chk("we_unexpected", 32'(bus.oWE), 32'h0);
                else begin
                    e = we_q.pop_front();
                    chk("we_addr", 32'(bus.oADDR), 32'(e.addr));
                    chk("we_data", 32'(bus.oDATA), 32'(e.data));
                    chk("we_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.oRE) begin
                if (re_q.size() == 0) chk("re_unexpected", 32'(bus.oRE), 32'h0);
                else begin
                    e = re_q.pop_front();
                    chk("re_addr", 32'(bus.oADDR), 32'(e.addr));
                    chk("re_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.oERR) begin
                if (err_q.size() == 0) chk("err_unexpected", 32'(bus.oERR), 32'h0);
                else begin
                    c = err_q.pop_front();
                    chk("err_cycle", 32'(cyc), 32'(c));
                end
            end
            if (bus.oTX_VALID && !prev_valid) begin
                if (tx_q.size() == 0) chk("tx_unexpected", 32'(bus.oTX_VALID), 32'h0);
                else begin
                    e = tx_q.pop_front();
                    chk("tx_data", 32'(bus.oTX_DATA), 32'(e.data));
                    chk("tx_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.oTX_VALID && prev_valid && !prev_ready)
                chk("tx_stable", 32'(bus.oTX_DATA), 32'(prev_data));
            if (prev_valid && prev_ready)
                chk("tx_drop_after_accept", 32'(bus.oTX_VALID), 32'h0);
            prev_valid = bus.oTX_VALID;
            prev_ready = bus.iTX_READY;
            prev_data  = bus.oTX_DATA;
        end
    end

    initial begin
        int n;
        int kind;
        RST_N         = 1'b0;
        bus.iRX_DATA  = 8'h00;
        bus.iRX_VALID = 1'b0;
        bus.iTX_READY = 1'b0;
        bus.iRD_EN    = 1'b0;
        bus.iRD       = 8'h00;
        repeat (3) step();
        RST_N = 1'b1;
        step();

        do_write(16'h0003, 8'hA5, 0, 1);
        do_read(16'h0005, 2, 8'h3C, 10, 1'b0, 1'b0);
        do_read(16'h0007, 0, 8'h00, 2, 1'b0, 1'b0);
        err_q.push_back(cyc + 1);
        send_byte(8'h41, 0, n);
        do_write(16'h1234, 8'h5A, 1, 0);
        do_read(16'hBEEF, 3, 8'hC3, 1, 1'b1, 1'b0);
        do_read(16'h00AA, TO, 8'h77, 0, 1'b0, 1'b0);
        do_read(16'h0F0F, 1, 8'h11, 0, 1'b0, 1'b0);
        stray_rd_en();
        step();

        send_byte(8'h57, 0, n);
        send_byte(8'h12, 0, n);
        do_reset(3);
        do_write(16'h4321, 8'h9C, 0, 2);
        do_read(16'h2222, 2, 8'h66, 0, 1'b0, 1'b1);
        do_write(16'h8001, 8'h01, 0, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: do_write(16'($urandom), 8'($urandom), 2, $urandom_range(0, 3));
                1: do_read(16'($urandom), $urandom_range(1, TO), 8'($urandom),
                           $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
                2: do_read(16'($urandom), 0, 8'($urandom),
                           $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
                default: begin
                    do_junk();
                    stray_rd_en();
                end
            endcase
        end

        repeat (TO + 5) step();
        chk("we_queue_drained", 32'(we_q.size()), 32'h0);
        chk("re_queue_drained", 32'(re_q.size()), 32'h0);
        chk("tx_queue_drained", 32'(tx_q.size()), 32'h0);
        chk("err_queue_drained", 32'(err_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
